// File: rtl/Falco_pkg.sv
// Falco shared integer issue-queue types and sizing.
// Used by the dispatch slot allocator and its free-slot picker.
package Falco_pkg;

  localparam int INT_IQ_NUM   = 8;
  localparam int INT_IQ_WIDTH = $clog2(INT_IQ_NUM);
  localparam int INT_IQ_CW    = INT_IQ_WIDTH + 1;

  typedef logic [INT_IQ_WIDTH-1:0] int_iq_idx_t;
  typedef logic [INT_IQ_NUM-1:0]   int_iq_mask_t;
  typedef logic [INT_IQ_CW-1:0]    int_iq_cnt_t;

endpackage

// File: rtl/int_iq_dispatch_slot_allocator_picker.sv
// Two-from-N rotating priority encoder over the INT_IQ free mask.
// idx0 is the first free slot at or after start_ptr, idx1 the next one.
module int_iq_free_slot_picker
  import Falco_pkg::*;
(
  input  int_iq_mask_t free_mask,
  input  int_iq_idx_t  start_ptr,
  output int_iq_idx_t  idx0,
  output int_iq_idx_t  idx1,
  output logic         valid0,
  output logic         valid1
);

  logic [2*INT_IQ_NUM-1:0] dbl;
  int_iq_mask_t            rot;
  int_iq_idx_t             off0;
  int_iq_idx_t             off1;

  // rotate so start_ptr sits at bit 0, take the two lowest set bits
  always_comb begin
    dbl    = {free_mask, free_mask} >> start_ptr;
    rot    = dbl[INT_IQ_NUM-1:0];
    off0   = '0;
    off1   = '0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    for (int i = 0; i < INT_IQ_NUM; i++) begin
      if (rot[i]) begin
        if (!valid0) begin
          valid0 = 1'b1;
          off0   = int_iq_idx_t'(i);
        end else if (!valid1) begin
          valid1 = 1'b1;
          off1   = int_iq_idx_t'(i);
        end
      end
    end
    idx0 = off0 + start_ptr;
    idx1 = off1 + start_ptr;
  end

endmodule

// File: rtl/int_iq_dispatch_slot_allocator.sv
// INT_IQ dispatch slot allocator: hands out up to two free slots per cycle.
// Define INT_IQ_ALLOC_ROTATE_EN for a rotating scan start pointer.
module int_iq_dispatch_slot_allocator
  import Falco_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dispatch_req0,
  input  logic                  dispatch_req1,
  output logic                  dispatch_ready,
  output logic [INT_IQ_WIDTH-1:0] dispatch_slot_idx0,
  output logic [INT_IQ_WIDTH-1:0] dispatch_slot_idx1,
  output logic                  dispatch_instr0_valid,
  output logic                  dispatch_instr1_valid,
  input  logic [INT_IQ_WIDTH-1:0] issue_slot_idx0,
  input  logic [INT_IQ_WIDTH-1:0] issue_slot_idx1,
  input  logic                  issue_slot_idx0_valid,
  input  logic                  issue_slot_idx1_valid,
  input  logic                  branch_miss_flush,
  input  logic                  dispatch_stall,
  output logic [INT_IQ_WIDTH:0] free_count,
  output logic                  iq_full,
  output logic                  alloc_error
);

  int_iq_mask_t occupied;
  int_iq_mask_t occ_nxt;
  int_iq_mask_t set_mask;
  int_iq_mask_t clr_mask;
  int_iq_cnt_t  fc_q;
  int_iq_cnt_t  fc_nxt;
  int_iq_cnt_t  need;
  int_iq_cnt_t  n_free;
  int_iq_cnt_t  n_alloc;
  logic         err_q;
  logic         err_nxt;
  logic         bad_free;
  logic         req_bad;
  logic         ready_raw;
  logic         fire0;
  logic         fire1;
  int_iq_idx_t  start_ptr;
  int_iq_idx_t  pick0;
  int_iq_idx_t  pick1;
  logic         pv0;
  logic         pv1;

`ifdef INT_IQ_ALLOC_ROTATE_EN
  int_iq_idx_t  alloc_ptr;

  // advance the scan start past the last slot handed out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
    end else if (fire1) begin
      alloc_ptr <= pick1 + int_iq_idx_t'(1);
    end else if (fire0) begin
      alloc_ptr <= pick0 + int_iq_idx_t'(1);
    end
  end

  assign start_ptr = alloc_ptr;
`else
  assign start_ptr = '0;
`endif

  int_iq_free_slot_picker u_picker (
    .free_mask (~occupied),
    .start_ptr (start_ptr),
    .idx0      (pick0),
    .idx1      (pick1),
    .valid0    (pv0),
    .valid1    (pv1)
  );

  assign req_bad = dispatch_req1 & ~dispatch_req0;
  assign need    = int_iq_cnt_t'(dispatch_req0)
                 + int_iq_cnt_t'(dispatch_req0 & dispatch_req1);

  // all-or-nothing acceptance; nothing leaves the block while in reset
  assign ready_raw = ~dispatch_stall & ~branch_miss_flush
                   & ~req_bad & (fc_q >= need);
  assign dispatch_ready = rst_n & ready_raw;

  assign fire0 = dispatch_req0 & dispatch_ready & pv0;
  assign fire1 = dispatch_req1 & fire0 & pv1;

  assign dispatch_instr0_valid = fire0;
  assign dispatch_instr1_valid = fire1;
  assign dispatch_slot_idx0    = rst_n ? pick0 : '0;
  assign dispatch_slot_idx1    = rst_n ? pick1 : '0;

  assign free_count  = fc_q;
  assign iq_full     = (fc_q == '0);
  assign alloc_error = err_q;

  // next occupancy, free count and error flag; flush wins over everything
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    bad_free = 1'b0;
    n_free   = '0;
    if (fire0) set_mask[pick0] = 1'b1;
    if (fire1) set_mask[pick1] = 1'b1;
    if (!branch_miss_flush) begin
      if (issue_slot_idx0_valid) begin
        if (occupied[issue_slot_idx0]) clr_mask[issue_slot_idx0] = 1'b1;
        else bad_free = 1'b1;
      end
      if (issue_slot_idx1_valid) begin
        if (occupied[issue_slot_idx1]) clr_mask[issue_slot_idx1] = 1'b1;
        else bad_free = 1'b1;
      end
    end
    for (int i = 0; i < INT_IQ_NUM; i++) begin
      n_free = n_free + int_iq_cnt_t'(clr_mask[i]);
    end
    n_alloc = int_iq_cnt_t'(fire0) + int_iq_cnt_t'(fire1);
    err_nxt = err_q | bad_free | req_bad;
    if (branch_miss_flush) begin
      occ_nxt = '0;
      fc_nxt  = int_iq_cnt_t'(INT_IQ_NUM);
    end else begin
      occ_nxt = (occupied & ~clr_mask) | set_mask;
      fc_nxt  = fc_q + n_free - n_alloc;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied <= '0;
      fc_q     <= int_iq_cnt_t'(INT_IQ_NUM);
      err_q    <= 1'b0;
    end else begin
      occupied <= occ_nxt;
      fc_q     <= fc_nxt;
      err_q    <= err_nxt;
    end
  end

endmodule
